// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to build in the optional parity bit (selected at run time by parity_mode).
module uart_tx_cfg #(
   parameter int CLK_F      = 50_000_000,
   parameter int UART_BPS   = 115200,
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tx_valid,
   input  logic [DATA_W-1:0]             tx_data,
   output logic                          tx_ready,
   input  logic [1:0]                    parity_mode,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CLK_GOAL = CLK_F / UART_BPS;
   localparam int STOP_LEN = STOP_BITS * CLK_GOAL;
   localparam int CNT_W    = $clog2(STOP_LEN + 1);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int LVL_W    = PTR_W + 1;
   localparam int IDX_W    = $clog2(DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    next_level;
   logic [DATA_W-1:0]   head;
   logic [DATA_W-1:0]   shreg;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    bit_idx;
   logic                push;
   logic                pop;
   logic                bit_end;
   logic                stop_end;

`ifdef UART_TX_PARITY_EN
   logic                send_par;
   logic                par_bit;
`else
   logic                unused_parity;
   assign unused_parity = ^parity_mode;
`endif

   assign push     = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];
   assign bit_end  = (cnt == CNT_W'(CLK_GOAL - 1));
   assign stop_end = (cnt == CNT_W'(STOP_LEN - 1));

   // A pop happens from IDLE, or on the very last stop cycle so the next frame follows with no gap.
   assign pop = (fifo_level != '0) && ((state == IDLE) || ((state == STOP) && stop_end));

   always_comb begin
      next_level = fifo_level;
      case ({push, pop})
         2'b10:   next_level = fifo_level + 1'b1;
         2'b01:   next_level = fifo_level - 1'b1;
         default: next_level = fifo_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level <= next_level;
         tx_ready   <= (next_level != LVL_W'(FIFO_DEPTH));
      end
   end

   // tx_done is raised one edge early so that, being registered, it lands on the final stop cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         send_par <= 1'b0;
         par_bit  <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg    <= head;
`ifdef UART_TX_PARITY_EN
                  send_par <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  par_bit  <= (^head) ^ (parity_mode == 2'b01);
`endif
                  cnt      <= '0;
                  uart_txd <= 1'b0;
                  tx_busy  <= 1'b1;
                  state    <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shreg[0];
                  shreg    <= shreg >> 1;
                  state    <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                     if (send_par) begin
                        uart_txd <= par_bit;
                        state    <= PARITY;
                     end else
`endif
                     begin
                        uart_txd <= 1'b1;
                        state    <= STOP;
                     end
                  end else begin
                     uart_txd <= shreg[0];
                     shreg    <= shreg >> 1;
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt      <= '0;
                  uart_txd <= 1'b1;
                  state    <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (stop_end) begin
                  cnt <= '0;
                  if (pop) begin
                     shreg    <= head;
`ifdef UART_TX_PARITY_EN
                     send_par <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                     par_bit  <= (^head) ^ (parity_mode == 2'b01);
`endif
                     uart_txd <= 1'b0;
                     state    <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  cnt     <= cnt + 1'b1;
                  tx_done <= (cnt == CNT_W'(STOP_LEN - 2));
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_F, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, 115200, baud rate; bit period CLK_GOAL = CLK_F / UART_BPS, integer truncation, SHALL be >= 2.
REQ-003 Parameter DATA_W, 8, data bits per frame, legal 5..9.
REQ-004 Parameter STOP_BITS, 1, stop bits per frame, legal 1 or 2.
REQ-005 Parameter FIFO_DEPTH, 4, transmit FIFO entries, power of two, 2..16.
REQ-006 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 tx_valid  input  1  write request for tx_data.
REQ-009 tx_data  input  DATA_W  word to transmit.
REQ-010 tx_ready  output  1  high when the FIFO is not full.
REQ-011 parity_mode  input  2  00 none, 01 odd, 10 even, 11 treated as none.
REQ-012 uart_txd  output  1  serial line, idle high.
REQ-013 tx_busy  output  1  high while a frame is on the line.
REQ-014 tx_done  output  1  one-cycle pulse at end of each frame.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 A word SHALL be accepted on an edge where tx_valid and tx_ready are both high; tx_valid while full SHALL be ignored, with no overwrite and no error.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-018 IDLE with FIFO non-empty SHALL pop the head word, latch it, sample parity_mode, and enter START; uart_txd SHALL be low in the cycle after the pop edge.
REQ-019 With an empty FIFO, uart_txd SHALL fall exactly one cycle after the accept edge.
REQ-020 Each START, DATA, PARITY and STOP bit SHALL last exactly CLK_GOAL cycles.
REQ-021 DATA SHALL send DATA_W bits LSB first.
REQ-022 PARITY SHALL be entered only when the sampled mode is 01 or 10: odd gives XOR of the data bits inverted, even gives XOR of the data bits.
REQ-023 STOP SHALL drive high for STOP_BITS*CLK_GOAL cycles.
REQ-024 Frame length SHALL be (1+DATA_W+P+STOP_BITS)*CLK_GOAL cycles, where P is 1 if a parity bit is sent and 0 otherwise.
REQ-025 tx_done SHALL pulse in the last cycle of the final stop bit.
REQ-026 In that same cycle, if the FIFO is non-empty, the FSM SHALL pop and go straight to START with no idle cycle (back-to-back frames); otherwise it SHALL go to IDLE.
REQ-027 parity_mode changes mid-frame SHALL NOT affect the current frame.
REQ-028 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 tx_busy SHALL be high from the first start-bit cycle through the last stop-bit cycle.

Reset
REQ-031 rst_n low SHALL immediately force uart_txd=1, tx_busy=0, tx_done=0, state IDLE, FIFO empty (fifo_level=0, tx_ready=1), and clear the bit and cycle counters, including mid-frame.
REQ-032 After release, no frame SHALL start until a new word is written.

Configuration
REQ-033 Macro UART_TX_PARITY_EN: when defined, parity_mode SHALL behave per REQ-011 and REQ-022.
REQ-034 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, parity_mode SHALL be ignored, and frames SHALL carry no parity bit.

Verification (CLK_F=50_000_000, UART_BPS=115200, CLK_GOAL=434)
REQ-035 Write 0x55 once in 8N1 -> uart_txd falls 1 cycle after accept; bits 0,1,0,1,0,1,0,1,0,1 each 434 cycles; tx_done pulses at cycle 4340 of the frame.
REQ-036 Macro defined, parity_mode=10, write 0x07 -> parity bit 1; with parity_mode=01 -> parity bit 0; frame length 4774 cycles.
REQ-037 DEPTH=4, hold tx_valid with 0x11..0x16 -> tx_ready drops when fifo_level=4; six back-to-back frames go out in order, no idle gap; exactly six tx_done pulses.
REQ-038 DATA_W=7, STOP_BITS=2, write 0x7F -> frame of 10*434 cycles; line high for the last 868 cycles.
REQ-039 Assert rst_n low during the 3rd data bit with 2 words queued -> uart_txd=1 and fifo_level=0 immediately; line stays high after release.
REQ-040 Macro undefined, parity_mode=10, write 0x07 -> 10-bit frame with no parity bit.
